// File: rtl/fit_input_arbiter.sv
// Round-robin reader of NSRC residual memories feeding the track-fit input stream.
// Drops all-zero words, buffers the rest in a credit-guarded FIFO behind a valid/ready output register.
module fit_input_arbiter #(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [NSRC*6-1:0]  number,
  output logic [NSRC*6-1:0]  addr,
  input  logic [NSRC*36-1:0] res_in,
  output logic [35:0]        res_out,
  output logic [2:0]         res_src,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [NSRC*6-1:0]  r_rem;
  logic [NSRC*6-1:0]  r_idx;
  logic [NSRC*6-1:0]  r_addr;
  logic [2:0]         r_rr;
  logic [MEM_LAT-1:0] r_pv;
  logic [2:0]         r_ps [MEM_LAT];
  logic [35:0]        r_fd [DEPTH];
  logic [2:0]         r_fs [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic [35:0]        r_out;
  logic [2:0]         r_src;
  logic               r_valid;
  logic               r_done;

  logic [3:0]  w_cand;
  logic        w_grant_any;
  logic [2:0]  w_grant_src;
  logic [2:0]  w_rr_next;
  logic [15:0] w_inflight;
  logic        w_credit_ok;
  logic        w_issue;
  logic [2:0]  w_exit_src;
  logic [35:0] w_exit_data;
  logic        w_wr;
  logic        w_rd;
  logic        w_any_rem;
  logic        w_drained;

  // First source with work, searching cyclically from the RR pointer.
  always_comb begin
    w_cand      = '0;
    w_grant_any = 1'b0;
    w_grant_src = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      w_cand = {1'b0, r_rr} + 4'(k);
      if (w_cand >= 4'(NSRC)) w_cand = w_cand - 4'(NSRC);
      if (!w_grant_any && (r_rem[w_cand*6 +: 6] != 6'd0)) begin
        w_grant_any = 1'b1;
        w_grant_src = w_cand[2:0];
      end
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int unsigned k = 0; k < MEM_LAT; k++) begin
      w_inflight = w_inflight + 16'(r_pv[k]);
    end
  end

  assign w_rr_next   = (w_grant_src == 3'(NSRC - 1)) ? 3'd0 : w_grant_src + 3'd1;
  assign w_credit_ok = (16'(r_cnt) + w_inflight) < 16'(DEPTH);
  assign w_issue     = (r_state == S_RUN) && w_grant_any && w_credit_ok && !start;
  assign w_exit_src  = r_ps[MEM_LAT-1];
  assign w_exit_data = res_in[w_exit_src*36 +: 36];
  assign w_wr        = r_pv[MEM_LAT-1] && (w_exit_data != 36'h0);
  assign w_rd        = (r_cnt != '0) && (!r_valid || res_ready);
  assign w_any_rem   = |r_rem;
  assign w_drained   = (w_inflight == '0) && (r_cnt == '0) && (!r_valid || res_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_addr  <= '1;
      r_rr    <= '0;
      r_pv    <= '0;
      for (int unsigned k = 0; k < MEM_LAT; k++) r_ps[k] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      // New event aborts the old one: anything still in flight or buffered is discarded.
      r_state <= (|number) ? S_RUN : S_DRAIN;
      r_rem   <= number;
      r_idx   <= '0;
      r_rr    <= '0;
      r_pv    <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) begin
        r_addr[w_grant_src*6 +: 6] <= r_idx[w_grant_src*6 +: 6];
        r_idx[w_grant_src*6 +: 6]  <= r_idx[w_grant_src*6 +: 6] + 6'd1;
        r_rem[w_grant_src*6 +: 6]  <= r_rem[w_grant_src*6 +: 6] - 6'd1;
        r_rr                       <= w_rr_next;
      end
      r_pv[0] <= w_issue;
      r_ps[0] <= w_grant_src;
      for (int unsigned k = 1; k < MEM_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_ps[k] <= r_ps[k-1];
      end
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      if (w_rd) begin
        r_out   <= r_fd[r_rp];
        r_src   <= r_fs[r_rp];
        r_valid <= 1'b1;
      end else if (r_valid && res_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_RUN:   if (!w_any_rem) r_state <= S_DRAIN;
        S_DRAIN: if (w_drained) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_fd[r_wp] <= w_exit_data;
      r_fs[r_wp] <= w_exit_src;
    end
  end

  assign addr      = r_addr;
  assign res_out   = r_out;
  assign res_src   = r_src;
  assign res_valid = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
